vga_timing: RTL and testbench

Generates 640x480@60 VGA raster timing: horizontal/vertical counters, active-low sync pulses, a visible-area flag and a once-per-frame `update` strobe. It drives the `vgax`/`vgay`/`update` inputs of the pixel generators, such as the ball and paddle objects, and the `hsync`/`vsync` pins of the VGA connector. Sync and visible outputs are delayed to line up with pixel generators that register their `pixel` output.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_timing_sync_delay.sv | 41 ++++
 rtl/vga_timing.sv | 122 ++++++++++++
 tb/tb_vga_timing.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, totals helpers and the sync flag bundle.
package vga_pkg;

  // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical).
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Coordinate widths: x and internal line counter are 10 bits, y port is 9.
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned CNT_W = 10;

  // Pixel divider width, enough for CLK_DIV up to 4.
  localparam int unsigned DIV_W = 2;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Flags that travel through the alignment pipeline together.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } sync_flags_t;

  // Blank, syncs inactive (high).
  localparam sync_flags_t FLAGS_RST = '{vis: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_timing_sync_delay.sv
// Fixed-depth shift register with an asynchronous active-low reset to a
// caller-supplied value; aligns sync/visible flags with registered pixels.
module sync_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Next value of each stage is the previous stage (stage 0 takes the input).
  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers, all forced to the reset value while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= rst_val;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Output is the last stage.
  always_comb q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel divider, h/v counters, delayed
// active-low syncs and visible flag, and a once-per-frame update strobe.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic           clck,
  input  logic           reset,
  output logic [X_W-1:0] vgax,
  output logic [Y_W-1:0] vgay,
  output logic           pix_en,
  output logic           update,
  output logic           visible,
  output logic           hsync,
  output logic           vsync
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_PRE_BLNK = CNT_W'(V_ACTIVE - 1);

  logic [DIV_W-1:0] div_q,    div_d;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             update_q, update_d;
  logic             pix_tick;
  logic             line_end;

  sync_flags_t raw_flags;
  sync_flags_t dly_flags;

  // Divider and raster counters; both counters wrap together on the last pixel.
  always_comb begin
    pix_tick = (div_q == DIV_LAST);
    line_end = pix_tick && (hcount_q == H_LAST);
    div_d    = pix_tick ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
    // Set on the edge that moves the raster to (0, V_ACTIVE).
    update_d = line_end && (vcount_q == V_PRE_BLNK);
  end

  // Counter and strobe registers.
  always_ff @(posedge clck or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      update_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      update_q <= update_d;
    end
  end

  // Undelayed visible and sync flags decoded from the counters.
  always_comb begin
    raw_flags.vis = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    raw_flags.hs  = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
    raw_flags.vs  = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      // Zero-depth path is a wire, but reset still has to force the idle values.
      always_comb dly_flags = reset ? raw_flags : FLAGS_RST;
    end else begin : g_delay
      sync_delay #(
        .DEPTH (PIPE_DELAY),
        .WIDTH ($bits(sync_flags_t))
      ) u_sync_delay (
        .clk     (clck),
        .rst_n   (reset),
        .rst_val (FLAGS_RST),
        .d       (raw_flags),
        .q       (dly_flags)
      );
    end
  endgenerate

  // Output mapping; pix_en is gated by reset so it reads 0 while held in reset.
  always_comb begin
    vgax    = hcount_q;
    vgay    = vcount_q[Y_W-1:0];
    pix_en  = pix_tick && reset;
    update  = update_q;
    visible = dly_flags.vis;
    hsync   = dly_flags.hs;
    vsync   = dly_flags.vs;
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing. Instance A: default horizontal timing,
// shortened vertical (8 active lines, 15 total), CLK_DIV=2, PIPE_DELAY=1.
// Instance B: same raster with CLK_DIV=1, PIPE_DELAY=0.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [9:0] vgax_a, vgax_b;
  logic [8:0] vgay_a, vgay_b;
  logic       pix_en_a, update_a, visible_a, hsync_a, vsync_a;
  logic       pix_en_b, update_b, visible_b, hsync_b, vsync_b;

  int checks = 0;
  int errors = 0;

  vga_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(2), .PIPE_DELAY(1)
  ) dut_a (
    .clck(clk), .reset(rst_a), .vgax(vgax_a), .vgay(vgay_a), .pix_en(pix_en_a),
    .update(update_a), .visible(visible_a), .hsync(hsync_a), .vsync(vsync_a)
  );

  vga_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(1), .PIPE_DELAY(0)
  ) dut_b (
    .clck(clk), .reset(rst_b), .vgax(vgax_b), .vgay(vgay_b), .pix_en(pix_en_b),
    .update(update_b), .visible(visible_b), .hsync(hsync_b), .vsync(vsync_b)
  );

  // Cycles since reset release for each instance (0 in the first cycle).
  int cyc_a = 0, cyc_b = 0;
  always @(posedge clk) begin
    cyc_a <= rst_a ? cyc_a + 1 : 0;
    cyc_b <= rst_b ? cyc_b + 1 : 0;
  end

  // Running tallies sampled mid-cycle.
  int vis_cnt_a = 0, upd_cnt_a = 0, upd_last_a = -1, upd_vis_a = 0, hs_low_a = 0;
  int vis_cnt_b = 0, upd_cnt_b = 0, nopix_b = 0;
  always @(negedge clk) begin
    if (rst_a) begin
      if (visible_a) vis_cnt_a++;
      if (!hsync_a) hs_low_a++;
      if (update_a) begin
        upd_cnt_a++;
        upd_last_a = cyc_a;
        if (visible_a) upd_vis_a++;
      end
    end
    if (rst_b) begin
      if (visible_b) vis_cnt_b++;
      if (update_b) upd_cnt_b++;
      if (!pix_en_b) nopix_b++;
    end
  end

  // Ball-style consumer stepped by update.
  int ball_q = 0;
  always @(posedge clk) if (update_a) ball_q <= ball_q + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_a(input int target);
    while (cyc_a < target) begin @(posedge clk); #1; end
  endtask

  task automatic wait_b(input int target);
    while (cyc_b < target) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  int n;
  int snap;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("a_rst_hsync", hsync_a, 1);
    check("a_rst_vsync", vsync_a, 1);
    check("a_rst_visible", visible_a, 0);
    check("a_rst_update", update_a, 0);
    check("a_rst_pix_en", pix_en_a, 0);
    check("a_rst_vgax", vgax_a, 0);
    check("a_rst_vgay", vgay_a, 0);

    @(negedge clk) rst_a = 1'b1;
    #1;
    check("a_k0_vgax", vgax_a, 0);
    check("a_k0_visible", visible_a, 0);
    check("a_k0_pix_en", pix_en_a, 0);
    wait_a(1);
    check("a_k1_pix_en", pix_en_a, 1);
    check("a_k1_vgax", vgax_a, 0);
    check("a_k1_visible", visible_a, 1);
    wait_a(2);
    check("a_k2_vgax", vgax_a, 1);
    check("a_k2_pix_en", pix_en_a, 0);

    wait_a(1279); check("a_vis_1279", visible_a, 1);
    wait_a(1280); check("a_vgax_1280", vgax_a, 640);
                  check("a_vis_lag_1280", visible_a, 1);
    wait_a(1281); check("a_vis_1281", visible_a, 0);
    wait_a(1312); check("a_vgax_1312", vgax_a, 656);
                  check("a_hs_1312", hsync_a, 1);
    wait_a(1313); check("a_hs_1313", hsync_a, 0);
    wait_a(1504); check("a_hs_1504", hsync_a, 0);
    wait_a(1505); check("a_hs_1505", hsync_a, 1);
    wait_a(1600); check("a_vgax_1600", vgax_a, 0);
                  check("a_vgay_1600", vgay_a, 1);
                  check("a_vis_1600", visible_a, 0);
    wait_a(1601); check("a_vis_1601", visible_a, 1);
    wait_a(2912); check("a_hs_2912", hsync_a, 1);
    wait_a(2913); check("a_hs_2913", hsync_a, 0);

    wait_a(12799); check("a_upd_12799", update_a, 0);
                   check("a_vgax_12799", vgax_a, 799);
                   check("a_vgay_12799", vgay_a, 7);
    wait_a(12800); check("a_upd_12800", update_a, 1);
                   check("a_vgay_12800", vgay_a, 8);
                   check("a_vis_12800", visible_a, 0);
    wait_a(12801); check("a_upd_12801", update_a, 0);
    wait_a(16000); check("a_vgay_16000", vgay_a, 10);
                   check("a_vs_16000", vsync_a, 1);
    wait_a(16001); check("a_vs_16001", vsync_a, 0);
    wait_a(19200); check("a_vs_19200", vsync_a, 0);
                   check("a_vgay_19200", vgay_a, 12);
    wait_a(19201); check("a_vs_19201", vsync_a, 1);
    wait_a(23999); check("a_vgax_23999", vgax_a, 799);
                   check("a_vgay_23999", vgay_a, 14);
    wait_a(24000); check("a_vgax_wrap", vgax_a, 0);
                   check("a_vgay_wrap", vgay_a, 0);
    wait_a(24001); check("a_vis_24001", visible_a, 1);

    wait_a(48001);
    check("a_vis_count_2frames", vis_cnt_a, 20480);
    check("a_update_count", upd_cnt_a, 2);
    check("a_update_last", upd_last_a, 36800);
    check("a_update_while_visible", upd_vis_a, 0);
    check("a_ball_steps", ball_q, 2);

    // Reset in the middle of the hsync pulse.
    n = 0;
    while (vgax_a !== 10'd700 && n < 1700) begin @(posedge clk); #1; n++; end
    check("a_reach_h700", vgax_a, 700);
    check("a_hs_at_700", hsync_a, 0);
    rst_a = 1'b0;
    #1;
    check("a_midrst_hsync", hsync_a, 1);
    check("a_midrst_vsync", vsync_a, 1);
    check("a_midrst_vgax", vgax_a, 0);
    check("a_midrst_visible", visible_a, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_a = 1'b1;
    #1;
    snap = hs_low_a;
    check("a_rel_vgax", vgax_a, 0);
    check("a_rel_hsync", hsync_a, 1);
    wait_a(1312);
    check("a_rel_vgax_1312", vgax_a, 656);
    check("a_rel_hs_1312", hsync_a, 1);
    check("a_rel_no_partial", hs_low_a - snap, 0);
    wait_a(1313); check("a_rel_hs_1313", hsync_a, 0);

    // Instance B: CLK_DIV=1, PIPE_DELAY=0.
    check("b_rst_pix_en", pix_en_b, 0);
    check("b_rst_visible", visible_b, 0);
    check("b_rst_hsync", hsync_b, 1);
    check("b_rst_vgax", vgax_b, 0);
    @(negedge clk) rst_b = 1'b1;
    #1;
    check("b_k0_vgax", vgax_b, 0);
    check("b_k0_visible", visible_b, 1);
    check("b_k0_pix_en", pix_en_b, 1);
    wait_b(1);   check("b_k1_vgax", vgax_b, 1);
    wait_b(655); check("b_vgax_655", vgax_b, 655);
                 check("b_hs_655", hsync_b, 1);
    wait_b(656); check("b_vgax_656", vgax_b, 656);
                 check("b_hs_656", hsync_b, 0);
    wait_b(751); check("b_hs_751", hsync_b, 0);
    wait_b(752); check("b_hs_752", hsync_b, 1);
    wait_b(800); check("b_vgax_800", vgax_b, 0);
                 check("b_vgay_800", vgay_b, 1);
    wait_b(6399); check("b_upd_6399", update_b, 0);
    wait_b(6400); check("b_upd_6400", update_b, 1);
                  check("b_vgay_6400", vgay_b, 8);
                  check("b_vis_6400", visible_b, 0);
    wait_b(12000);
    check("b_vgax_wrap", vgax_b, 0);
    check("b_vgay_wrap", vgay_b, 0);
    check("b_vis_count_frame", vis_cnt_b, 5120);
    check("b_update_count", upd_cnt_b, 1);
    check("b_pix_en_gaps", nopix_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
